// File: rtl/fft_bf_sequencer.sv
// Address/strobe sequencer for an in-place radix-2 DIT FFT on one shared butterfly.
// Issues A/B/twiddle reads per butterfly and replays the A/B pair as writes after the read+butterfly latency.
module fft_bf_sequencer #(
  parameter int NPOINTS = 16,
  parameter int LOG2N   = 4,
  parameter int RD_LAT  = 1,
  parameter int BF_LAT  = 4,
  localparam int SW = (LOG2N / 2 > $clog2(LOG2N)) ? LOG2N / 2 : $clog2(LOG2N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);
  localparam int WR_DLY = RD_LAT + BF_LAT;
  localparam int KW     = LOG2N - 1;
  localparam int DW     = $clog2(WR_DLY + 1);
  localparam logic [KW-1:0] K_LAST = KW'(NPOINTS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(WR_DLY - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic             vld;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
  } wr_slot_t;

  state_t           state, state_nx;
  logic [KW-1:0]    k;
  logic [DW-1:0]    dcnt;
  wr_slot_t         dly [WR_DLY];
  logic             run_last, drain_last;
  logic [LOG2N-1:0] kx, hmask, pos, a_iss, b_iss, tw_full;

  assign run_last   = (k == K_LAST);
  assign drain_last = (dcnt == D_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (run_last) state_nx = DRAIN;
      DRAIN:   if (drain_last) state_nx = (stage == S_LAST) ? DONE : RUN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      stage <= '0;
      dcnt  <= '0;
    end else begin
      unique case (state)
        RUN: k <= run_last ? '0 : k + 1'b1;
        DRAIN: begin
          if (drain_last) begin
            dcnt <= '0;
            if (stage != S_LAST) stage <= stage + 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE:    stage <= '0;
        default: ;
      endcase
    end
  end

  // Splice a zero into k at bit 'stage': the low bits are pos, the high bits are the group.
  always_comb begin
    kx      = {1'b0, k};
    hmask   = (LOG2N'(1) << stage) - LOG2N'(1);
    pos     = kx & hmask;
    a_iss   = ((kx & ~hmask) << 1) | pos;
    b_iss   = a_iss | (LOG2N'(1) << stage);
    tw_full = pos << (KW - int'(stage));
  end

  always_comb begin
    rd_en     = (state == RUN);
    busy      = (state != IDLE);
    done      = (state == DONE);
    rd_addr_a = rd_en ? a_iss : '0;
    rd_addr_b = rd_en ? b_iss : '0;
    tw_addr   = rd_en ? tw_full[KW-1:0] : '0;
  end

  // Write-back delay line; reset drops in-flight writes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WR_DLY; i++) dly[i] <= '0;
    end else begin
      dly[0] <= '{vld: rd_en, a: rd_addr_a, b: rd_addr_b};
      for (int i = 1; i < WR_DLY; i++) dly[i] <= dly[i-1];
    end
  end

  assign wr_en     = dly[WR_DLY-1].vld;
  assign wr_addr_a = dly[WR_DLY-1].a;
  assign wr_addr_b = dly[WR_DLY-1].b;
endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Scoreboard bench for fft_bf_sequencer: a transform-level model pushes expected reads,
// writes, done and busy windows; a negedge monitor pops and compares.
module tb_fft_bf_sequencer;
  localparam int N = 16, L = 4, WR = 5, HALF_N = N / 2, STG = HALF_N + WR, MAXC = 4096;

  logic       clk = 1'b0, rst_n, start;
  logic       busy, done, rd_en, wr_en;
  logic [1:0] stage;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_addr;
  logic [24:0] outv;

  fft_bf_sequencer #(.NPOINTS(N), .LOG2N(L), .RD_LAT(1), .BF_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b));

  assign outv = {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, fails = 0;

  typedef struct {int c; int s; int k; int a; int b; int tw;} rd_e_t;
  typedef struct {int c; int a; int b;} wr_e_t;
  rd_e_t rdq[$];
  wr_e_t wrq[$];
  int    doneq[$];
  bit    exp_busy [MAXC];
  int    free_c = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", n, cyc, act, exp);
    end
  endtask

  // One whole transform starting its first read at cycle c0, from the address formulas.
  function automatic void schedule(input int c0);
    for (int s = 0; s < L; s++) begin
      for (int k = 0; k < HALF_N; k++) begin
        int half, pos, a, rc;
        half = 1 << s;
        pos  = k % half;
        a    = (k / half) * 2 * half + pos;
        rc   = c0 + s * STG + k;
        rdq.push_back('{rc, s, k, a, a + half, pos * (1 << (L - 1 - s))});
        wrq.push_back('{rc + WR, a, a + half});
      end
    end
    doneq.push_back(c0 + L * STG);
    for (int c = c0; c <= c0 + L * STG; c++) if (c < MAXC) exp_busy[c] = 1'b1;
    free_c = c0 + L * STG + 1;
  endfunction

  task automatic flush();
    rdq.delete();
    wrq.delete();
    doneq.delete();
    for (int c = cyc; c < MAXC; c++) exp_busy[c] = 1'b0;
  endtask

  task automatic step(input bit s);
    start = s;
    if (s && rst_n && cyc >= free_c) schedule(cyc + 1);
    @(posedge clk); #1;
  endtask

  task automatic dir_chk(input int a, input int b, input int tw);
    chk("dir_rd_a", rd_addr_a, a);
    chk("dir_rd_b", rd_addr_b, b);
    chk("dir_tw", tw_addr, tw);
  endtask

  int wcnt = 0;
  int wmask = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", int'(outv), 0);
      wcnt  = 0;
      wmask = 0;
    end else begin
      if (cyc < MAXC) chk("busy", busy, exp_busy[cyc]);
      if (rd_en) begin
        if (rdq.size() == 0) chk("rd_spurious", 1, 0);
        else begin
          rd_e_t e;
          e = rdq.pop_front();
          chk("rd_cycle", cyc, e.c);
          chk("rd_stage", stage, e.s);
          chk("rd_a", rd_addr_a, e.a);
          chk("rd_b", rd_addr_b, e.b);
          chk("rd_tw", tw_addr, e.tw);
          if (e.s == 0 && e.k == 3) dir_chk(6, 7, 0);
          if (e.s == 1 && e.k == 3) dir_chk(5, 7, 4);
          if (e.s == 2 && e.k == 5) dir_chk(9, 13, 2);
          if (e.s == 3 && e.k == 7) dir_chk(7, 15, 7);
        end
      end
      if (wr_en) begin
        if (wrq.size() == 0) chk("wr_spurious", 1, 0);
        else begin
          wr_e_t w;
          w = wrq.pop_front();
          chk("wr_cycle", cyc, w.c);
          chk("wr_a", wr_addr_a, w.a);
          chk("wr_b", wr_addr_b, w.b);
        end
        wmask = wmask | (1 << wr_addr_a) | (1 << wr_addr_b);
        wcnt++;
        if (wcnt == HALF_N) begin
          chk("wr_stage_cover", wmask, 32'hFFFF);
          wcnt  = 0;
          wmask = 0;
        end
      end
      if (done) begin
        if (doneq.size() == 0) chk("done_spurious", 1, 0);
        else chk("done_cycle", cyc, doneq.pop_front());
      end
    end
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    free_c = cyc;

    // Single transform with extra start pulses at transform cycles 10 and 40.
    step(0); step(0);
    c0 = cyc + 1;
    step(1);
    repeat (58) step(cyc == c0 + 10 || cyc == c0 + 40);

    // Sparse random start pulses.
    repeat (400) step($urandom_range(19, 0) == 0);
    repeat (60) step(0);

    // start held high: back-to-back transforms.
    repeat (120) step(1);
    repeat (60) step(0);

    // Reset during stage 2 DRAIN.
    step(0);
    c0 = cyc + 1;
    step(1);
    while (cyc < c0 + 2 * STG + HALF_N + 2) step(0);
    #2;
    chk("pre_rst_wr_en", wr_en, 1);
    chk("pre_rst_stage", stage, 2);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", int'(outv), 0);
    flush();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    free_c = cyc;
    step(0);
    step(1);
    repeat (60) step(0);

    chk("rdq_empty", rdq.size(), 0);
    chk("wrq_empty", wrq.size(), 0);
    chk("doneq_empty", doneq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
